// File: rtl/psum_accumulator.sv
// Accumulates PE partial sums across input-channel tiles in a psum RAM and emits finished pixels through an output FIFO.
// Latency: result in cycle t appears on o_vld in t+3. Backpressure: o_in_rdy drops below 3 free FIFO slots; a push into a full FIFO is dropped and flagged.
module psum_accumulator #(
  parameter int Tout       = 4,
  parameter int W_PSUM     = 32,
  parameter int W_SIZE     = 8,
  parameter int W_CHANNEL  = 8,
  parameter int PSUM_AW    = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_vld,
  input  logic [Tout*W_PSUM-1:0] i_acc_flat,
  input  logic [W_SIZE-1:0]      i_row,
  input  logic [W_SIZE-1:0]      i_col,
  input  logic [W_CHANNEL-1:0]   i_chn_out,
  input  logic                   i_first_cin,
  input  logic                   i_last_cin,
  input  logic [W_SIZE-1:0]      i_cfg_cols,
  input  logic [W_CHANNEL-1:0]   i_cfg_ctiles,
  output logic                   o_in_rdy,
  output logic                   o_vld,
  output logic [Tout*W_PSUM-1:0] o_data,
  output logic [W_SIZE-1:0]      o_row,
  output logic [W_SIZE-1:0]      o_col,
  output logic [W_CHANNEL-1:0]   o_chn_out,
  input  logic                   i_rdy,
  output logic                   o_busy,
  output logic                   o_overflow
);

  localparam int W_ACC = Tout * W_PSUM;
  localparam int FA    = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [W_ACC-1:0]     dat;
    logic [W_SIZE-1:0]    row;
    logic [W_SIZE-1:0]    col;
    logic [W_CHANNEL-1:0] chn;
  } ent_t;

  logic               s1_vld, s2_vld;
  logic               s1_first, s2_first, s1_last, s2_last;
  ent_t               s1_ent, s2_ent;
  logic [PSUM_AW-1:0] addr_c, s1_addr, s2_addr;

  logic [W_ACC-1:0]   psum_mem [2**PSUM_AW];
  logic [W_ACC-1:0]   ram_q;
  logic [W_ACC-1:0]   base_dat, sum_dat;

  logic               wr1_vld, wr2_vld;
  logic [PSUM_AW-1:0] wr1_addr, wr2_addr;
  logic [W_ACC-1:0]   wr1_dat, wr2_dat;

  ent_t               fifo_mem [FIFO_DEPTH];
  ent_t               fifo_head;
  logic [FA:0]        wr_ptr, rd_ptr, fifo_cnt;
  logic [FA+2:0]      occ;
  logic               fifo_full, fifo_empty, push_req, push, pop;

  // Address arithmetic is done modulo 2**PSUM_AW, which equals truncating the full product.
  always_comb begin
    addr_c = (PSUM_AW'(i_row) * PSUM_AW'(i_cfg_cols) + PSUM_AW'(i_col))
             * PSUM_AW'(i_cfg_ctiles) + PSUM_AW'(i_chn_out);
  end

  always_ff @(posedge clk) begin
    s1_ent   <= {i_acc_flat, i_row, i_col, i_chn_out};
    s1_first <= i_first_cin;
    s1_last  <= i_last_cin;
    s1_addr  <= addr_c;
    s2_ent   <= s1_ent;
    s2_first <= s1_first;
    s2_last  <= s1_last;
    s2_addr  <= s1_addr;
    wr1_addr <= s2_addr;
    wr1_dat  <= sum_dat;
    wr2_addr <= wr1_addr;
    wr2_dat  <= wr1_dat;
  end

  // Read-old-on-collision RAM; the read for S2 is issued during S1.
  always_ff @(posedge clk) begin
    if (s2_vld) psum_mem[s2_addr] <= sum_dat;
    ram_q <= psum_mem[s1_addr];
  end

  always_comb begin
    base_dat = ram_q;
    sum_dat  = '0;
    if (s2_first)                            base_dat = '0;
    else if (wr1_vld && wr1_addr == s2_addr) base_dat = wr1_dat;
    else if (wr2_vld && wr2_addr == s2_addr) base_dat = wr2_dat;
    for (int g = 0; g < Tout; g++)
      sum_dat[g*W_PSUM +: W_PSUM] = base_dat[g*W_PSUM +: W_PSUM] + s2_ent.dat[g*W_PSUM +: W_PSUM];
  end

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_cnt == (FA+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && i_rdy;
  assign push_req   = s2_vld && s2_last;
  assign push       = push_req && (!fifo_full || pop);
  assign fifo_head  = fifo_mem[rd_ptr[FA-1:0]];

  // Each in-flight result holds a FIFO slot until it retires.
  assign occ      = (FA+3)'(fifo_cnt) + (FA+3)'(s1_vld) + (FA+3)'(s2_vld);
  assign o_in_rdy = (occ <= (FA+3)'(FIFO_DEPTH - 3));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[FA-1:0]] <= {sum_dat, s2_ent.row, s2_ent.col, s2_ent.chn};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
      wr1_vld    <= 1'b0;
      wr2_vld    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      s1_vld  <= i_vld;
      s2_vld  <= s1_vld;
      wr1_vld <= s2_vld;
      wr2_vld <= wr1_vld;
      if (push) wr_ptr <= wr_ptr + (FA+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (FA+1)'(1);
      if (push_req && !push) o_overflow <= 1'b1;
    end
  end

  // Head fields read as zero while empty so the outputs have clean reset values.
  assign o_vld     = !fifo_empty;
  assign o_data    = o_vld ? fifo_head.dat : '0;
  assign o_row     = o_vld ? fifo_head.row : '0;
  assign o_col     = o_vld ? fifo_head.col : '0;
  assign o_chn_out = o_vld ? fifo_head.chn : '0;
  assign o_busy    = s1_vld || s2_vld || !fifo_empty;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: latency, accumulation/forwarding, lane wrap, backpressure, reset and a tile sweep.
module tb_psum_accumulator;
  localparam int TOUT = 4, WP = 32, WS = 8, WC = 8, AW = 12, FD = 8;
  localparam int WA   = TOUT * WP;
  localparam int WPOS = 2 * WS + WC;

  typedef logic [WA+WPOS-1:0] ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_vld, i_first_cin, i_last_cin, i_rdy;
  logic [WA-1:0] i_acc_flat;
  logic [WS-1:0] i_row, i_col, i_cfg_cols;
  logic [WC-1:0] i_chn_out, i_cfg_ctiles;
  logic          o_in_rdy, o_vld, o_busy, o_overflow;
  logic [WA-1:0] o_data;
  logic [WS-1:0] o_row, o_col;
  logic [WC-1:0] o_chn_out;

  always #5 clk = ~clk;

  psum_accumulator #(.Tout(TOUT), .W_PSUM(WP), .W_SIZE(WS), .W_CHANNEL(WC),
                     .PSUM_AW(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_acc_flat(i_acc_flat),
    .i_row(i_row), .i_col(i_col), .i_chn_out(i_chn_out),
    .i_first_cin(i_first_cin), .i_last_cin(i_last_cin),
    .i_cfg_cols(i_cfg_cols), .i_cfg_ctiles(i_cfg_ctiles),
    .o_in_rdy(o_in_rdy), .o_vld(o_vld), .o_data(o_data),
    .o_row(o_row), .o_col(o_col), .o_chn_out(o_chn_out),
    .i_rdy(i_rdy), .o_busy(o_busy), .o_overflow(o_overflow)
  );

  int            n_chk = 0, n_pass = 0, w;
  ent_t          got_q[$];
  ent_t          exp_q[$];
  ent_t          e;
  logic [WA-1:0] acc6;
  logic [WA-1:0] ref_m [0:3][0:3][0:1];

  task automatic check(string tag, logic [WA-1:0] got, logic [WA-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [WA-1:0] lanes(logic [31:0] l3, logic [31:0] l2, logic [31:0] l1, logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [WA-1:0] ladd(logic [WA-1:0] a, logic [WA-1:0] b);
    logic [WA-1:0] r;
    r = '0;
    for (int g = 0; g < TOUT; g++) r[g*WP +: WP] = a[g*WP +: WP] + b[g*WP +: WP];
    return r;
  endfunction

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(logic [WA-1:0] acc, logic [WS-1:0] row, logic [WS-1:0] col,
                      logic [WC-1:0] chn, logic first, logic last);
    i_vld = 1'b1; i_acc_flat = acc; i_row = row; i_col = col; i_chn_out = chn;
    i_first_cin = first; i_last_cin = last;
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  task automatic expect_out(string tag, logic [WA-1:0] dat, logic [WPOS-1:0] pos);
    ent_t x;
    int   t = 0;
    while (got_q.size() == 0 && t < 40) begin @(posedge clk); #1; t++; end
    check({tag, "_present"}, WA'(got_q.size() != 0), WA'(1));
    if (got_q.size() != 0) begin
      x = got_q.pop_front();
      check({tag, "_dat"}, x[WA+WPOS-1 -: WA], dat);
      check({tag, "_pos"}, WA'(x[WPOS-1:0]), WA'(pos));
    end
  endtask

  // Capture every accepted head away from the active edge.
  always @(negedge clk)
    if (!rst && o_vld && i_rdy) got_q.push_back({o_data, o_row, o_col, o_chn_out});

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_vld = 1'b0; i_acc_flat = '0; i_row = '0; i_col = '0; i_chn_out = '0;
    i_first_cin = 1'b0; i_last_cin = 1'b0; i_rdy = 1'b1;
    i_cfg_cols = 8'd4; i_cfg_ctiles = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy",   WA'(o_in_rdy),   WA'(1));
    check("rst_vld",      WA'(o_vld),      WA'(0));
    check("rst_data",     o_data,          WA'(0));
    check("rst_pos",      WA'({o_row, o_col, o_chn_out}), WA'(0));
    check("rst_busy",     WA'(o_busy),     WA'(0));
    check("rst_overflow", WA'(o_overflow), WA'(0));
    rst = 1'b0;
    idle(2);

    // 1: single first+last result, latency 3
    send(lanes(4, 3, 2, 1), 8'd0, 8'd1, 8'd0, 1'b1, 1'b1);
    check("t1_vld_c1", WA'(o_vld), WA'(0));
    check("t1_busy",   WA'(o_busy), WA'(1));
    idle(1);
    check("t1_vld_c2", WA'(o_vld), WA'(0));
    idle(1);
    check("t1_vld_c3", WA'(o_vld), WA'(1));
    expect_out("t1", lanes(4, 3, 2, 1), {8'd0, 8'd1, 8'd0});
    idle(3);
    check("t1_idle", WA'(o_busy), WA'(0));

    // 2: three cin tiles on one pixel at spacing 0, 1, 2
    for (int sp = 0; sp < 3; sp++) begin
      send({4{32'd10}}, 8'd1, 8'd2, 8'd0, 1'b1, 1'b0);
      idle(sp);
      send({4{32'hFFFFFFFD}}, 8'd1, 8'd2, 8'd0, 1'b0, 1'b0);
      idle(sp);
      send({4{32'd5}}, 8'd1, 8'd2, 8'd0, 1'b0, 1'b1);
      expect_out($sformatf("t2_sp%0d", sp), {4{32'd12}}, {8'd1, 8'd2, 8'd0});
    end

    // 3: two's-complement wrap per lane
    send(lanes(32'hFFFFFFFF, 32'h80000000, 32'd2, 32'h7FFFFFFF), 8'd3, 8'd0, 8'd0, 1'b1, 1'b0);
    send(lanes(32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFB, 32'd1), 8'd3, 8'd0, 8'd0, 1'b0, 1'b1);
    expect_out("t3", lanes(32'hFFFFFFFE, 32'h0, 32'hFFFFFFFD, 32'h80000000), {8'd3, 8'd0, 8'd0});

    // 4: backpressure, forced overflow, in-order drain
    idle(2);
    got_q.delete();
    i_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_in_rdy_%0d", k), WA'(o_in_rdy), WA'(k <= 5));
      send(lanes(32'(k+300), 32'(k+200), 32'(k+100), 32'(k)), 8'(2 + k/4), 8'(k%4), 8'd0, 1'b1, 1'b1);
    end
    idle(3);
    check("t4_full_in_rdy", WA'(o_in_rdy),   WA'(0));
    check("t4_no_ovf_yet",  WA'(o_overflow), WA'(0));
    send(lanes(32'd308, 32'd208, 32'd108, 32'd8), 8'd4, 8'd0, 8'd0, 1'b1, 1'b1);
    idle(3);
    check("t4_ovf",       WA'(o_overflow),   WA'(1));
    check("t4_held",      WA'(got_q.size()), WA'(0));
    i_rdy = 1'b1;
    idle(14);
    check("t4_drain_cnt", WA'(got_q.size()), WA'(8));
    check("t4_ovf_sticky", WA'(o_overflow),  WA'(1));
    for (int k = 0; k < 8; k++)
      expect_out($sformatf("t4_q%0d", k), lanes(32'(k+300), 32'(k+200), 32'(k+100), 32'(k)),
                 {8'(2 + k/4), 8'(k%4), 8'd0});
    // dropped push still updated the RAM
    send('0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b1);
    expect_out("t4_ramwr", lanes(32'd308, 32'd208, 32'd108, 32'd8), {8'd4, 8'd0, 8'd0});

    // 5: reset with 3 in flight and 2 queued
    idle(2);
    got_q.delete();
    i_rdy = 1'b0;
    for (int k = 0; k < 4; k++)
      send({4{32'(k+50)}}, 8'd5, 8'(k), 8'd0, 1'b1, 1'b1);
    i_vld = 1'b1; i_acc_flat = {4{32'd54}}; i_col = 8'd4;
    rst = 1'b1;
    idle(1);
    i_vld = 1'b0;
    check("t5_vld",      WA'(o_vld),      WA'(0));
    check("t5_data",     o_data,          WA'(0));
    check("t5_pos",      WA'({o_row, o_col, o_chn_out}), WA'(0));
    check("t5_busy",     WA'(o_busy),     WA'(0));
    check("t5_in_rdy",   WA'(o_in_rdy),   WA'(1));
    check("t5_overflow", WA'(o_overflow), WA'(0));
    rst = 1'b0;
    i_rdy = 1'b1;
    idle(8);
    check("t5_no_out", WA'(got_q.size()), WA'(0));
    send(lanes(9, 8, 7, 6), 8'd3, 8'd0, 8'd0, 1'b1, 1'b1);
    expect_out("t5_fresh", lanes(9, 8, 7, 6), {8'd3, 8'd0, 8'd0});

    // 6: 4x4 sweep, 2 chn_out tiles, 3 cin tiles, random acc and i_rdy
    idle(2);
    got_q.delete();
    exp_q.delete();
    i_cfg_ctiles = 8'd2;
    for (int cin = 0; cin < 3; cin++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          for (int ch = 0; ch < 2; ch++) begin
            w = 0;
            i_rdy = 1'($urandom_range(0, 1));
            while (!o_in_rdy && w < 200) begin
              i_rdy = 1'($urandom_range(0, 1));
              idle(1);
              w++;
            end
            acc6 = {$urandom, $urandom, $urandom, $urandom};
            ref_m[r][c][ch] = (cin == 0) ? acc6 : ladd(ref_m[r][c][ch], acc6);
            if (cin == 2) exp_q.push_back({ref_m[r][c][ch], 8'(r), 8'(c), 8'(ch)});
            send(acc6, 8'(r), 8'(c), 8'(ch), 1'(cin == 0), 1'(cin == 2));
          end
    i_rdy = 1'b1;
    w = 0;
    while (got_q.size() < exp_q.size() && w < 400) begin idle(1); w++; end
    idle(2);
    check("t6_count",    WA'(got_q.size()), WA'(exp_q.size()));
    check("t6_overflow", WA'(o_overflow),   WA'(0));
    check("t6_idle",     WA'(o_busy),       WA'(0));
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      expect_out($sformatf("t6_o%0d", k), e[WA+WPOS-1 -: WA], e[WPOS-1:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
